// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RISC-V sequencing controller: Moore FSM that shares one ALU and one
// memory port between fetch and data access, stalls on mem_ready, traps on bad opcodes.
module multicycle_control_fsm #(
    parameter int RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [6:0]          opcode,
    input  logic                Zero,
    input  logic                mem_ready,
    output logic                PCWrite,
    output logic                IRWrite,
    output logic                IorD,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                MemtoReg,
    output logic                RegWrite,
    output logic                ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [1:0]          ALUOp,
    output logic                PCSource,
    output logic                illegal,
    output logic [3:0]          state_out,
    output logic [RETIRE_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_ADDR   = 4'd2,
        S_MEM_RD = 4'd3,
        S_WB_MEM = 4'd4,
        S_MEM_WR = 4'd5,
        S_EXEC   = 4'd6,
        S_WB_ALU = 4'd7,
        S_BRANCH = 4'd8,
        S_TRAP   = 4'd9
    } state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    state_t state;
    state_t state_next;
    logic   retire;
    logic   illegal_q;

    // Next-state and retire decode; encodings 10-15 fall back to FETCH.
    always_comb begin
        state_next = S_FETCH;
        retire     = 1'b0;
        case (state)
            S_FETCH:  state_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_next = S_ADDR;
                    OP_R, OP_I:        state_next = S_EXEC;
                    OP_BEQ:            state_next = S_BRANCH;
                    default:           state_next = S_TRAP;
                endcase
            end
            S_ADDR:   state_next = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: state_next = mem_ready ? S_WB_MEM : S_MEM_RD;
            S_WB_MEM: retire = 1'b1;
            S_MEM_WR: begin
                state_next = mem_ready ? S_FETCH : S_MEM_WR;
                retire     = mem_ready;
            end
            S_EXEC:   state_next = S_WB_ALU;
            S_WB_ALU: retire = 1'b1;
            S_BRANCH: retire = 1'b1;
            S_TRAP:   state_next = S_TRAP;
            default:  state_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_FETCH;
            instr_count <= '0;
            illegal_q   <= 1'b0;
        end else begin
            state <= state_next;
            if (retire)
                instr_count <= instr_count + RETIRE_W'(1);
            if (state_next == S_TRAP)
                illegal_q <= 1'b1;
        end
    end

    // Datapath controls decode straight from the registered state; PCWrite/IRWrite
    // also follow mem_ready/Zero in the same cycle. Reset masks every control.
    always_comb begin
        PCWrite  = 1'b0;
        IRWrite  = 1'b0;
        IorD     = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        MemtoReg = 1'b0;
        RegWrite = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 2'b00;
        ALUOp    = 2'b00;
        PCSource = 1'b0;
        case (state)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE: ALUSrcB = 2'b11;
            S_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEM_RD: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
            end
            S_WB_MEM: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            S_MEM_WR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
                ALUSrcB = (opcode == OP_R) ? 2'b00 : 2'b10;
            end
            S_WB_ALU: RegWrite = 1'b1;
            S_BRANCH: begin
                ALUSrcA  = 1'b1;
                ALUOp    = 2'b01;
                PCSource = 1'b1;
                PCWrite  = Zero;
            end
            default: ;
        endcase
        if (reset) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            IorD     = 1'b0;
            MemRead  = 1'b0;
            MemWrite = 1'b0;
            MemtoReg = 1'b0;
            RegWrite = 1'b0;
            ALUSrcA  = 1'b0;
            ALUSrcB  = 2'b00;
            ALUOp    = 2'b00;
            PCSource = 1'b0;
        end
    end

    assign illegal   = illegal_q;
    assign state_out = state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: directed and random instruction streams checked
// against a per-instruction state-path model; retire counter modelled modulo 16.
module tb_multicycle_control_fsm;

    localparam int RW = 4;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_BAD   = 7'b1111111;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [6:0]    opcode = '0;
    logic          Zero = 1'b0;
    logic          mem_ready = 1'b0;
    logic          PCWrite, IRWrite, IorD, MemRead, MemWrite, MemtoReg, RegWrite;
    logic          ALUSrcA, PCSource, illegal;
    logic [1:0]    ALUSrcB, ALUOp;
    logic [3:0]    state_out;
    logic [RW-1:0] instr_count;

    int errors = 0;
    int checks = 0;
    int exp_count = 0;
    int st_q[$];
    logic mr_q[$];

    always #5 clk = ~clk;

    multicycle_control_fsm #(.RETIRE_W(RW)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .Zero(Zero), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
        .illegal(illegal), .state_out(state_out), .instr_count(instr_count)
    );

    wire [13:0] ctrl = {PCWrite, IRWrite, IorD, MemRead, MemWrite, MemtoReg, RegWrite,
                        ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal};
    wire [4:0] strobes = {PCWrite, IRWrite, MemRead, MemWrite, RegWrite};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Control table by state name, straight from the datapath description.
    function automatic logic [13:0] exp_ctrl(input int st, input logic [6:0] op,
                                             input logic mr, input logic z);
        logic pcw, irw, iord, mrd, mwr, m2r, rw, asa, pcs, ill;
        logic [1:0] asb, aop;
        {pcw, irw, iord, mrd, mwr, m2r, rw, asa, pcs, ill} = '0;
        asb = 2'b00;
        aop = 2'b00;
        case (st)
            0: begin mrd = 1; asb = 2'b01; pcw = mr; irw = mr; end
            1: asb = 2'b11;
            2: begin asa = 1; asb = 2'b10; end
            3: begin iord = 1; mrd = 1; end
            4: begin m2r = 1; rw = 1; end
            5: begin iord = 1; mwr = 1; end
            6: begin asa = 1; aop = 2'b10; asb = (op == OP_R) ? 2'b00 : 2'b10; end
            7: rw = 1;
            8: begin asa = 1; aop = 2'b01; pcs = 1; pcw = z; end
            9: ill = 1;
            default: ;
        endcase
        return {pcw, irw, iord, mrd, mwr, m2r, rw, asa, asb, aop, pcs, ill};
    endfunction

    task automatic step(input int st, input logic mr, input logic [6:0] op, input logic z);
        @(negedge clk);
        opcode = op;
        mem_ready = mr;
        Zero = z;
        #1;
        chk("state", 32'(state_out), 32'(st));
        chk("ctrl", 32'(ctrl), 32'(exp_ctrl(st, op, mr, z)));
    endtask

    task automatic do_reset(input int held_state);
        @(negedge clk);
        reset = 1'b1;
        mem_ready = 1'b0;
        #1;
        chk("reset_strobes", 32'(strobes), 32'd0);
        if (held_state >= 0) chk("reset_cycle_state", 32'(state_out), 32'(held_state));
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_reset_state", 32'(state_out), 32'd0);
        chk("post_reset_count", 32'(instr_count), 32'd0);
        chk("post_reset_illegal", 32'(illegal), 32'd0);
        exp_count = 0;
    endtask

    // Build the expected state path for one instruction, then walk it cycle by cycle.
    task automatic run_instr(input logic [6:0] op, input int fs, input int ms, input logic z);
        st_q.delete();
        mr_q.delete();
        for (int i = 0; i < fs; i++) begin st_q.push_back(0); mr_q.push_back(1'b0); end
        st_q.push_back(0); mr_q.push_back(1'b1);
        st_q.push_back(1); mr_q.push_back(1'($urandom));
        if (op == OP_R || op == OP_I) begin
            st_q.push_back(6); mr_q.push_back(1'($urandom));
            st_q.push_back(7); mr_q.push_back(1'($urandom));
        end else if (op == OP_LOAD) begin
            st_q.push_back(2); mr_q.push_back(1'($urandom));
            for (int i = 0; i < ms; i++) begin st_q.push_back(3); mr_q.push_back(1'b0); end
            st_q.push_back(3); mr_q.push_back(1'b1);
            st_q.push_back(4); mr_q.push_back(1'($urandom));
        end else if (op == OP_STORE) begin
            st_q.push_back(2); mr_q.push_back(1'($urandom));
            for (int i = 0; i < ms; i++) begin st_q.push_back(5); mr_q.push_back(1'b0); end
            st_q.push_back(5); mr_q.push_back(1'b1);
        end else begin
            st_q.push_back(8); mr_q.push_back(1'($urandom));
        end
        for (int i = 0; i < st_q.size(); i++) begin
            step(st_q[i], mr_q[i], op, z);
            if (i == 0) chk("instr_count", 32'(instr_count), 32'(exp_count));
        end
        exp_count = (exp_count + 1) % 16;
    endtask

    initial begin
        logic [6:0] ops [5];
        ops = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BEQ};

        do_reset(-1);
        run_instr(OP_R, 0, 0, 1'b0);
        run_instr(OP_LOAD, 0, 2, 1'b0);
        run_instr(OP_BEQ, 0, 0, 1'b1);
        run_instr(OP_BEQ, 1, 0, 1'b0);
        run_instr(OP_STORE, 2, 1, 1'b0);
        run_instr(OP_I, 0, 0, 1'b1);

        // Illegal opcode: trap holds through opcode/mem_ready noise until reset.
        step(0, 1'b1, OP_BAD, 1'b0);
        step(1, 1'b0, OP_BAD, 1'b0);
        for (int i = 0; i < 24; i++) begin
            step(9, 1'($urandom), 7'($urandom), 1'($urandom));
            chk("trap_count", 32'(instr_count), 32'(exp_count));
        end
        do_reset(9);

        // Store abandoned by reset during a stalled MEM_WR.
        run_instr(OP_R, 0, 0, 1'b0);
        step(0, 1'b1, OP_STORE, 1'b0);
        step(1, 1'b1, OP_STORE, 1'b0);
        step(2, 1'b1, OP_STORE, 1'b0);
        step(5, 1'b0, OP_STORE, 1'b0);
        step(5, 1'b0, OP_STORE, 1'b0);
        do_reset(5);

        // Sixteen retirements wrap the 4-bit counter back to zero.
        for (int i = 0; i < 16; i++) run_instr(OP_R, 0, 0, 1'b0);
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        chk("wrap_count", 32'(instr_count), 32'd0);

        for (int i = 0; i < 40; i++)
            run_instr(ops[$urandom_range(0, 4)], $urandom_range(0, 2),
                      $urandom_range(0, 3), 1'($urandom));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
